// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 raster geometry for vga_timing_counter and vga_sync.
//   Holds the porch/retrace breakdown, the pixel clock divider and the
//   coordinate and counter widths.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_RETRACE = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_RETRACE = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    // 100 MHz system clock -> 25 MHz pixel rate
    localparam int CLK_DIV   = 4;
    localparam int CLK_DIV_MAX = 16;
    localparam int DIV_W     = 4;

    localparam int COORD_W   = 10;
    localparam int FRAME_W   = 8;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_counter_pixel_tick_gen.sv
// pixel_tick_gen
//   Divides the system clock down to a one-clock pixel-enable strobe.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     en       in   run enable; low holds the divider phase
//     clr      in   synchronous clear of the divider
//     pix_tick out  one-clk strobe every CLK_DIV enabled clocks
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic pix_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // rst_n gating keeps the strobe low during reset even when CLK_DIV=1
    // (where the last-phase compare is always true); clr suppresses it too.
    assign pix_tick = rst_n && en && !clr && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_counter.sv
// vga_timing_counter
//   Pixel timebase and raster position counters feeding vga_sync.
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     en        in   run enable; low freezes everything and masks pulses
//     clr       in   synchronous clear of divider, h/v and frame counters
//     pix_tick  out  one-clk pixel strobe
//     h_count   out  horizontal position 0..H_TOTAL-1 (registered)
//     v_count   out  vertical position 0..V_TOTAL-1 (registered)
//     line_end  out  pulse on the last pixel of a line
//     frame_end out  pulse on the last pixel of a frame
//     frame_cnt out  completed-frame count, wraps
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
    parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
    parameter int FRAME_W = vga_timing_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    output logic               pix_tick,
    output logic [9:0]         h_count,
    output logic [9:0]         v_count,
    output logic               line_end,
    output logic               frame_end,
    output logic [FRAME_W-1:0] frame_cnt
);

    if (H_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL < 1 || V_TOTAL > 1024 ||
        CLK_DIV < 1 || CLK_DIV > CLK_DIV_MAX) begin : g_param_check
        $error("vga_timing_counter: illegal H_TOTAL/V_TOTAL/CLK_DIV");
    end

    localparam coord_t H_LAST = COORD_W'(H_TOTAL - 1);
    localparam coord_t V_LAST = COORD_W'(V_TOTAL - 1);

    coord_t             h_q, h_d;
    coord_t             v_q, v_d;
    logic [FRAME_W-1:0] fc_q, fc_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .pix_tick (pix_tick)
    );

    // pix_tick already carries en, !clr and reset masking
    assign line_end  = pix_tick && (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fc_d = fc_q;
        if (clr) begin
            h_d  = '0;
            v_d  = '0;
            fc_d = '0;
        end else if (pix_tick) begin
            h_d = line_end ? '0 : h_q + 1'b1;
            if (line_end) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end
            if (frame_end) begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            fc_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            fc_q <= fc_d;
        end
    end

    assign h_count   = h_q;
    assign v_count   = v_q;
    assign frame_cnt = fc_q;

endmodule

// File: tb/tb_vga_timing_counter.sv
// tb_vga_timing_counter
//   Directed bench with three parameterisations sharing clk/rst_n/en/clr:
//     dut_a: default 800x525 geometry, CLK_DIV=4
//     dut_b: 8x4 raster, CLK_DIV=2 (frame wrap, frame_cnt wrap, clr)
//     dut_c: 4x2 raster, CLK_DIV=1
module tb_vga_timing_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;

    logic       a_pix, a_le, a_fe;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_pix, b_le, b_fe;
    logic [9:0] b_h, b_v;
    logic [7:0] b_fc;
    logic       c_pix, c_le, c_fe;
    logic [9:0] c_h, c_v;
    logic [7:0] c_fc;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    vga_timing_counter #(.CLK_DIV(4), .H_TOTAL(800), .V_TOTAL(525), .FRAME_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .pix_tick(a_pix), .h_count(a_h), .v_count(a_v),
        .line_end(a_le), .frame_end(a_fe), .frame_cnt(a_fc)
    );

    vga_timing_counter #(.CLK_DIV(2), .H_TOTAL(8), .V_TOTAL(4), .FRAME_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .pix_tick(b_pix), .h_count(b_h), .v_count(b_v),
        .line_end(b_le), .frame_end(b_fe), .frame_cnt(b_fc)
    );

    vga_timing_counter #(.CLK_DIV(1), .H_TOTAL(4), .V_TOTAL(2), .FRAME_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .pix_tick(c_pix), .h_count(c_h), .v_count(c_v),
        .line_end(c_le), .frame_end(c_fe), .frame_cnt(c_fc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned k);
        repeat (k) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;

        // reset held for 3 clocks
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_a_pix", a_pix, 0);
            chk("rst_a_h", a_h, 0);
            chk("rst_a_v", a_v, 0);
            chk("rst_a_le", a_le, 0);
            chk("rst_a_fc", a_fc, 0);
            chk("rst_c_pix", c_pix, 0);
        end
        rst_n = 1'b1;
        #1;
        // n = edges since release
        chk("n0_a_pix", a_pix, 0);
        chk("n0_c_pix", c_pix, 1);
        chk("n0_c_h", c_h, 0);
        run(1);
        chk("n1_a_pix", a_pix, 0);
        run(1);
        chk("n2_a_pix", a_pix, 0);
        run(1);
        chk("n3_a_pix", a_pix, 1);
        chk("n3_a_h", a_h, 0);
        chk("n3_c_h", c_h, 3);
        chk("n3_c_le", c_le, 1);
        chk("n3_c_fe", c_fe, 0);
        run(1);
        chk("n4_a_pix", a_pix, 0);
        chk("n4_a_h", a_h, 1);
        chk("n4_c_h", c_h, 0);
        chk("n4_c_v", c_v, 1);
        run(3);
        chk("n7_a_pix", a_pix, 1);
        chk("n7_a_h", a_h, 1);
        chk("n7_c_fe", c_fe, 1);
        chk("n7_c_fc", c_fc, 0);
        run(1);
        chk("n8_a_h", a_h, 2);
        chk("n8_c_v", c_v, 0);
        chk("n8_c_fc", c_fc, 1);
        run(3);
        chk("n11_a_pix", a_pix, 1);

        // line wrap at h=799, v=0
        run(3188);
        chk("lw_a_h", a_h, 799);
        chk("lw_a_v", a_v, 0);
        chk("lw_a_le", a_le, 1);
        chk("lw_a_fe", a_fe, 0);
        run(1);
        chk("lw_next_h", a_h, 0);
        chk("lw_next_v", a_v, 1);
        chk("lw_next_le", a_le, 0);

        // enable hold at h=100, div=2
        run(402);
        chk("eh_h_pre", a_h, 100);
        chk("eh_v_pre", a_v, 1);
        en = 1'b0;
        run(10);
        chk("eh_h_hold", a_h, 100);
        chk("eh_pix_hold", a_pix, 0);
        chk("eh_le_hold", a_le, 0);
        en = 1'b1;
        #1;
        chk("eh_pix_resume", a_pix, 0);
        run(1);
        chk("eh_pix_tick", a_pix, 1);
        chk("eh_h_tick", a_h, 100);
        en = 1'b0;
        #1;
        chk("eh_pix_masked", a_pix, 0);
        run(2);
        chk("eh_h_masked", a_h, 100);
        en = 1'b1;
        #1;
        chk("eh_pix_unmask", a_pix, 1);
        run(1);
        chk("eh_h_101", a_h, 101);

        // async reset mid-line at h=350
        run(998);
        chk("ar_h_pre", a_h, 350);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_h", a_h, 0);
        chk("ar_v", a_v, 0);
        chk("ar_pix", a_pix, 0);
        chk("ar_c_pix", c_pix, 0);
        run(3);
        rst_n = 1'b1;
        #1;
        chk("ar_rel_pix", a_pix, 0);
        run(3);
        chk("ar_n3_pix", a_pix, 1);
        chk("ar_n3_h", a_h, 0);
        run(1);
        chk("ar_n4_h", a_h, 1);

        // dut_b: frame wrap and frame_cnt wrap from a fresh reset
        rst_n = 1'b0;
        step();
        chk("b_rst_h", b_h, 0);
        chk("b_rst_fc", b_fc, 0);
        rst_n = 1'b1;
        #1;
        run(15);
        chk("b_lw_h", b_h, 7);
        chk("b_lw_le", b_le, 1);
        chk("b_lw_fe", b_fe, 0);
        run(1);
        chk("b_lw_next_h", b_h, 0);
        chk("b_lw_next_v", b_v, 1);
        run(47);
        chk("b_fw_h", b_h, 7);
        chk("b_fw_v", b_v, 3);
        chk("b_fw_le", b_le, 1);
        chk("b_fw_fe", b_fe, 1);
        chk("b_fw_fc", b_fc, 0);
        run(1);
        chk("b_fw_next_h", b_h, 0);
        chk("b_fw_next_v", b_v, 0);
        chk("b_fw_next_fc", b_fc, 1);
        chk("b_fw_next_fe", b_fe, 0);
        run(16256);
        chk("b_fc_255", b_fc, 255);
        run(63);
        chk("b_wrap_fe", b_fe, 1);
        run(1);
        chk("b_fc_wrap", b_fc, 0);

        // clr coincident with a frame_end tick
        run(127);
        chk("cl_pre_fe", b_fe, 1);
        chk("cl_pre_fc", b_fc, 1);
        clr = 1'b1;
        #1;
        chk("cl_pix", b_pix, 0);
        chk("cl_le", b_le, 0);
        chk("cl_fe", b_fe, 0);
        run(1);
        chk("cl_h", b_h, 0);
        chk("cl_v", b_v, 0);
        chk("cl_fc", b_fc, 0);
        chk("cl_a_h", a_h, 0);
        clr = 1'b0;
        #1;
        chk("cl_rel_pix", b_pix, 0);
        run(1);
        chk("cl_n1_pix", b_pix, 1);
        chk("cl_n1_h", b_h, 0);
        run(1);
        chk("cl_n2_h", b_h, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
